// File: rtl/stream_skid_stage_pkg.sv
// stream_pkg: shared beat payload and skid-state types for the stream skid stage
package stream_pkg;
  localparam int BEAT_W = 8;
  typedef struct packed {
    logic              last;
    logic [BEAT_W-1:0] x;
  } beat_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
endpackage

// File: rtl/stream_skid_stage_if.sv
// stream_if: valid/ready stream carrying beat_t, with payload-inverting helper z
interface stream_if;
  import stream_pkg::*;
  logic  valid;
  logic  ready;
  beat_t data;
  function automatic logic [BEAT_W-1:0] z(input logic [BEAT_W-1:0] x);
    return ~x;
  endfunction
  modport sink(input valid, input data, output ready, import z);
  modport source(output valid, output data, input ready);
endinterface

// File: rtl/stream_skid_stage.sv
// stream_skid_stage: two-entry registered skid buffer with optional payload inversion and beat/packet counters
module stream_skid_stage
  import stream_pkg::*;
#(
  parameter int WIDTH  = BEAT_W,
  parameter int INVERT = 0
) (
  input  logic        clk,
  input  logic        rst,
  stream_if.sink      up,
  stream_if.source    dn,
  output logic        parity,
  output logic [15:0] beats,
  output logic [15:0] pkts
);
  skid_state_t state_q, state_d;
  beat_t       main_q, main_d, skid_q, skid_d, in_xf;
  logic [15:0] beats_q, beats_d, pkts_q, pkts_d;
  logic        rdy, vld, fire_up, fire_dn;
  function automatic logic z(input beat_t x);
    return ^x.x[WIDTH-1:0];
  endfunction
  assign rdy      = (state_q != FULL) & ~rst;
  assign vld      = (state_q != EMPTY) & ~rst;
  assign fire_up  = up.valid & rdy;
  assign fire_dn  = vld & dn.ready;
  assign up.ready = rdy;
  assign dn.valid = vld;
  assign dn.data  = main_q;
  assign parity   = vld ? z(main_q) : 1'b0;
  assign beats    = beats_q;
  assign pkts     = pkts_q;
  // next state, data steering and counter increments; skid only fills when main is busy and not draining
  always_comb begin
    in_xf   = '{last: up.data.last, x: (INVERT != 0) ? up.z(up.data.x) : up.data.x};
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    beats_d = beats_q + 16'(fire_dn);
    pkts_d  = pkts_q + 16'(fire_dn & main_q.last);
    unique case (state_q)
      EMPTY: begin
        state_d = fire_up ? ONE : EMPTY;
        main_d  = fire_up ? in_xf : main_q;
      end
      ONE: begin
        state_d = (fire_up & ~fire_dn) ? FULL : (fire_dn & ~fire_up) ? EMPTY : ONE;
        skid_d  = (fire_up & ~fire_dn) ? in_xf : skid_q;
        main_d  = (fire_up & fire_dn) ? in_xf : main_q;
      end
      FULL: begin
        state_d = fire_dn ? ONE : FULL;
        main_d  = fire_dn ? skid_q : main_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // state, payload registers and counters; reset drops both entries and clears counters together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      beats_q <= '0;
      pkts_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      beats_q <= beats_d;
      pkts_q  <= pkts_d;
    end
  end
endmodule

// File: tb/tb_stream_skid_stage.sv
// tb_stream_skid_stage: directed self-checking bench for stream_skid_stage (raw and inverting instances)
module tb_stream_skid_stage;
  import stream_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        par0, par1;
  logic [15:0] beats0, pkts0, beats1, pkts1;
  int          n_pass = 0;
  int          n_chk = 0;
  stream_if u0();
  stream_if d0();
  stream_if u1();
  stream_if d1();
  stream_skid_stage #(.WIDTH(8), .INVERT(0)) dut0 (
    .clk(clk), .rst(rst), .up(u0), .dn(d0), .parity(par0), .beats(beats0), .pkts(pkts0)
  );
  stream_skid_stage #(.WIDTH(8), .INVERT(1)) dut1 (
    .clk(clk), .rst(rst), .up(u1), .dn(d1), .parity(par1), .beats(beats1), .pkts(pkts1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic send0(input logic v, input logic l, input logic [7:0] x);
    u0.valid = v;
    u0.data  = '{last: l, x: x};
  endtask
  initial begin
    send0(1'b1, 1'b0, 8'h55);
    d0.ready = 1'b0;
    u1.valid = 1'b0;
    u1.data  = '0;
    d1.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_up_ready", 32'(u0.ready), 32'h0);
    chk("rst_dn_valid", 32'(d0.valid), 32'h0);
    chk("rst_beats", 32'(beats0), 32'h0);
    rst = 1'b0;
    send0(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("rel_up_ready", 32'(u0.ready), 32'h1);
    chk("rel_dn_valid", 32'(d0.valid), 32'h0);
    d0.ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      send0(1'b1, 1'b0, 8'(i));
      @(negedge clk);
      chk($sformatf("stream_x_%0d", i), {23'd0, d0.valid, d0.data.x}, {23'd0, 1'b1, 8'(i)});
    end
    send0(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("stream_beats", 32'(beats0), 32'd10);
    chk("stream_drained", 32'(d0.valid), 32'h0);
    d0.ready = 1'b0;
    send0(1'b1, 1'b0, 8'hA5);
    @(negedge clk);
    send0(1'b1, 1'b0, 8'h3C);
    @(negedge clk);
    chk("bp_full_ready", 32'(u0.ready), 32'h0);
    chk("bp_head_a5", 32'(d0.data.x), 32'hA5);
    send0(1'b1, 1'b0, 8'h70);
    @(negedge clk);
    chk("bp_held_ready", 32'(u0.ready), 32'h0);
    chk("bp_held_a5", 32'(d0.data.x), 32'hA5);
    chk("bp_parity_a5", 32'(par0), 32'h0);
    d0.ready = 1'b1;
    @(negedge clk);
    chk("bp_second_3c", 32'(d0.data.x), 32'h3C);
    chk("bp_beats_11", 32'(beats0), 32'd11);
    @(negedge clk);
    chk("bp_third_70", 32'(d0.data.x), 32'h70);
    chk("bp_parity_70", 32'(par0), 32'h1);
    chk("bp_beats_12", 32'(beats0), 32'd12);
    send0(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("bp_beats_13", 32'(beats0), 32'd13);
    chk("bp_idle_parity", 32'(par0), 32'h0);
    chk("bp_pkts_0", 32'(pkts0), 32'h0);
    d1.ready = 1'b1;
    u1.valid = 1'b1;
    u1.data  = '{last: 1'b1, x: 8'h0F};
    @(negedge clk);
    u1.valid = 1'b0;
    chk("inv_x_f0", 32'(d1.data.x), 32'hF0);
    chk("inv_last", 32'(d1.data.last), 32'h1);
    chk("inv_parity", 32'(par1), 32'h0);
    @(negedge clk);
    chk("inv_pkts_1", 32'(pkts1), 32'h1);
    chk("inv_beats_1", 32'(beats1), 32'h1);
    d0.ready = 1'b0;
    send0(1'b1, 1'b0, 8'h11);
    @(negedge clk);
    send0(1'b1, 1'b0, 8'h22);
    @(negedge clk);
    chk("mid_full", 32'(u0.ready), 32'h0);
    send0(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(d0.valid), 32'h0);
    chk("mid_rst_beats", 32'(beats0), 32'h0);
    rst = 1'b0;
    d0.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_no_emit_%0d", i), {15'd0, d0.valid, beats0}, 32'h0);
    end
    send0(1'b1, 1'b0, 8'h5A);
    repeat (65534) @(negedge clk);
    send0(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("wrap_fffe", 32'(beats0), 32'hFFFE);
    send0(1'b1, 1'b0, 8'hC1);
    @(negedge clk);
    send0(1'b1, 1'b0, 8'hC2);
    @(negedge clk);
    chk("wrap_ffff", 32'(beats0), 32'hFFFF);
    send0(1'b1, 1'b0, 8'hC3);
    @(negedge clk);
    chk("wrap_0000", 32'(beats0), 32'h0000);
    send0(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("wrap_0001", 32'(beats0), 32'h0001);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
